// File: rtl/corr_seq_pkg.sv
// corr_seq_pkg: shared correlator widths and sequencer state encoding.
package corr_seq_pkg;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_COUNT_W = 5;
    localparam int DEF_LAG_W   = 4;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/corr_addr_gen.sv
// corr_addr_gen: k/lag counters and modulo x/y address pair generation.
module corr_addr_gen #(
    parameter int ADDR_W  = 8,
    parameter int COUNT_W = 5,
    parameter int LAG_W   = 4
) (
    input  logic               ck,
    input  logic               rst_n,
    input  logic               en,
    input  logic               load,
    input  logic               step,
    input  logic [ADDR_W-1:0]  base,
    input  logic [COUNT_W-1:0] count,
    input  logic [LAG_W-1:0]   lags,
    output logic [ADDR_W-1:0]  x_raddr,
    output logic [ADDR_W-1:0]  y_raddr,
    output logic               first,
    output logic               last,
    output logic [LAG_W-1:0]   lag_idx,
    output logic               fin
);
    logic [COUNT_W-1:0] k, k_n;
    logic [LAG_W-1:0]   lag_n;
    logic [ADDR_W-1:0]  x_n, y_n;
    logic               first_n, last_n;

    // fin marks the final pair of the final lag currently on the outputs
    assign fin = last && (lag_idx == lags - LAG_W'(1));

    always_comb begin
        k_n     = '0;
        lag_n   = '0;
        x_n     = '0;
        y_n     = '0;
        first_n = 1'b0;
        last_n  = 1'b0;
        if (load) begin
            x_n     = base;
            y_n     = base;
            first_n = 1'b1;
            last_n  = count == COUNT_W'(1);
        end else if (step && last) begin
            lag_n   = lag_idx + LAG_W'(1);
            x_n     = base;
            y_n     = base + ADDR_W'(lag_n);
            first_n = 1'b1;
            last_n  = count == COUNT_W'(1);
        end else if (step) begin
            k_n    = k + COUNT_W'(1);
            lag_n  = lag_idx;
            x_n    = x_raddr + ADDR_W'(1);
            y_n    = y_raddr + ADDR_W'(1);
            last_n = k_n == count - COUNT_W'(1);
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            lag_idx <= '0;
            x_raddr <= '0;
            y_raddr <= '0;
            first   <= 1'b0;
            last    <= 1'b0;
        end else if (en) begin
            k       <= k_n;
            lag_idx <= lag_n;
            x_raddr <= x_n;
            y_raddr <= y_n;
            first   <= first_n;
            last    <= last_n;
        end
    end
endmodule

// File: rtl/corr_seq.sv
// corr_seq: multi-lag autocorrelation fetch sequencer with first/last framing.
module corr_seq
    import corr_seq_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int LAG_W   = DEF_LAG_W
) (
    input  logic               ck,
    input  logic               rst_n,
    input  logic               en,
    input  logic               start,
    input  logic               abort,
    input  logic [COUNT_W-1:0] count,
    input  logic [LAG_W-1:0]   lags,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic [ADDR_W-1:0]  x_raddr,
    output logic [ADDR_W-1:0]  y_raddr,
    output logic               ren,
    output logic               first,
    output logic               last,
    output logic [LAG_W-1:0]   lag_idx,
    output logic               busy,
    output logic               done
);
    state_t             state, state_n;
    logic [COUNT_W-1:0] count_r, cur_count;
    logic [LAG_W-1:0]   lags_r, cur_lags;
    logic [ADDR_W-1:0]  base_r, cur_base;
    logic               nz, load, step, fin, ren_n, busy_n, done_n;

    // while idle the live inputs feed the generator so pair 0 issues on the start edge
    assign cur_count = (state == IDLE) ? count : count_r;
    assign cur_lags  = (state == IDLE) ? lags : lags_r;
    assign cur_base  = (state == IDLE) ? base_addr : base_r;
    assign nz        = (count != '0) && (lags != '0);
    assign load      = (state == IDLE) && start && !abort && nz;
    assign step      = (state == RUN) && !abort && !fin;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count_r <= '0;
            lags_r  <= '0;
            base_r  <= '0;
            ren     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (en) begin
            state <= state_n;
            ren   <= ren_n;
            busy  <= busy_n;
            done  <= done_n;
            if (load) begin
                count_r <= count;
                lags_r  <= lags;
                base_r  <= base_addr;
            end
        end
    end

    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = load ? RUN : IDLE;
        else if (abort || fin)
            state_n = IDLE;
    end

    always_comb begin
        ren_n  = state_n == RUN;
        busy_n = state_n == RUN;
        done_n = !abort && (((state == RUN) && fin) || ((state == IDLE) && start && !nz));
    end

    corr_addr_gen #(
        .ADDR_W (ADDR_W),
        .COUNT_W(COUNT_W),
        .LAG_W  (LAG_W)
    ) u_addr_gen (
        .ck     (ck),
        .rst_n  (rst_n),
        .en     (en),
        .load   (load),
        .step   (step),
        .base   (cur_base),
        .count  (cur_count),
        .lags   (cur_lags),
        .x_raddr(x_raddr),
        .y_raddr(y_raddr),
        .first  (first),
        .last   (last),
        .lag_idx(lag_idx),
        .fin    (fin)
    );
endmodule

// File: tb/tb_corr_seq.sv
// tb_corr_seq: directed checks of corr_seq address pairs, framing and handshake.
module tb_corr_seq;
    logic       ck = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] count = '0;
    logic [3:0] lags = '0;
    logic [7:0] base_addr = '0;
    logic [7:0] x_raddr, y_raddr;
    logic       ren, first, last, busy, done;
    logic [3:0] lag_idx;
    int         n_vec = 0;
    int         n_err = 0;

    corr_seq dut (
        .ck       (ck),
        .rst_n    (rst_n),
        .en       (en),
        .start    (start),
        .abort    (abort),
        .count    (count),
        .lags     (lags),
        .base_addr(base_addr),
        .x_raddr  (x_raddr),
        .y_raddr  (y_raddr),
        .ren      (ren),
        .first    (first),
        .last     (last),
        .lag_idx  (lag_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 ck = ~ck;

    function automatic logic [31:0] pk(logic r, logic b, logic d, logic f, logic l,
                                       logic [3:0] lg, logic [7:0] x, logic [7:0] y);
        return {7'b0, r, b, d, f, l, lg, x, y};
    endfunction

    wire [31:0] obs = {7'b0, ren, busy, done, first, last, lag_idx, x_raddr, y_raddr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // issue a start, then scramble the parameter inputs to prove they were latched
    task automatic issue(input int b, input int c, input int l);
        base_addr = 8'(b);
        count     = 5'(c);
        lags      = 4'(l);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        base_addr = 8'h5A;
        count     = 5'd3;
        lags      = 4'd7;
    endtask

    task automatic expect_seq(input string nm, input int b, input int c, input int lg);
        for (int l = 0; l < lg; l++)
            for (int k = 0; k < c; k++) begin
                chk($sformatf("%s l%0d k%0d", nm, l, k), obs,
                    pk(1, 1, 0, k == 0, k == c - 1, 4'(l), 8'(b + k), 8'(b + k + l)));
                tick();
            end
        chk({nm, " done"}, obs, pk(0, 0, 1, 0, 0, 0, 0, 0));
    endtask

    initial begin
        #3;
        chk("reset", obs, pk(0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle", obs, pk(0, 0, 0, 0, 0, 0, 0, 0));

        issue(8'h00, 12, 1);
        expect_seq("c12", 8'h00, 12, 1);
        tick();
        chk("c12 done drop", obs, pk(0, 0, 0, 0, 0, 0, 0, 0));

        issue(8'hFC, 8, 3);
        expect_seq("wrap", 8'hFC, 8, 3);
        tick();

        issue(8'h30, 1, 4);
        expect_seq("c1", 8'h30, 1, 4);
        tick();

        issue(8'h10, 0, 3);
        chk("count0", obs, pk(0, 0, 1, 0, 0, 0, 0, 0));
        tick();
        chk("count0 after", obs, pk(0, 0, 0, 0, 0, 0, 0, 0));
        issue(8'h10, 4, 0);
        chk("lags0", obs, pk(0, 0, 1, 0, 0, 0, 0, 0));
        tick();
        chk("lags0 after", obs, pk(0, 0, 0, 0, 0, 0, 0, 0));

        // start held high while busy is ignored, then taken on the done cycle
        issue(8'h10, 3, 1);
        base_addr = 8'h80;
        count     = 5'd2;
        lags      = 4'd1;
        start     = 1'b1;
        expect_seq("busy", 8'h10, 3, 1);
        tick();
        start = 1'b0;
        expect_seq("b2b", 8'h80, 2, 1);
        tick();

        issue(8'h00, 12, 2);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("abort k%0d", k), obs, pk(1, 1, 0, k == 0, 0, 0, 8'(k), 8'(k)));
            if (k == 4) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        chk("abort off", obs, pk(0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("abort no done", obs, pk(0, 0, 0, 0, 0, 0, 0, 0));

        issue(8'hF0, 5, 2);
        for (int l = 0; l < 2; l++)
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("en l%0d k%0d", l, k), obs,
                    pk(1, 1, 0, k == 0, k == 4, 4'(l), 8'(8'hF0 + k), 8'(8'hF0 + k + l)));
                if (k == 1 || k == 4) begin
                    en = 1'b0;
                    tick();
                    tick();
                    chk($sformatf("en hold l%0d k%0d", l, k), obs,
                        pk(1, 1, 0, k == 0, k == 4, 4'(l), 8'(8'hF0 + k), 8'(8'hF0 + k + l)));
                    en = 1'b1;
                end
                tick();
            end
        chk("en done", obs, pk(0, 0, 1, 0, 0, 0, 0, 0));
        tick();

        issue(8'h20, 6, 2);
        tick();
        tick();
        chk("rst pre", obs, pk(1, 1, 0, 0, 0, 0, 8'h22, 8'h22));
        #2 rst_n = 1'b0;
        #1 chk("rst async", obs, pk(0, 0, 0, 0, 0, 0, 0, 0));
        #1 rst_n = 1'b1;
        tick();
        chk("rst after", obs, pk(0, 0, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/corr_seq.md
# corr_seq

Multi-lag fetch sequencer for the correlator datapath; the parametrised successor of the single-stream fetch counter. On one start command it walks every lag 0..lags-1 of an autocorrelation over a circular sample buffer. For each lag it issues a contiguous burst of read address pairs (x, y = x + lag) to the sample dual-port RAMs, with first/last framing that drives the MAC's clear and the result capture.

## Interface
Parameters:
- ADDR_W, 8, sample RAM address width; addresses wrap modulo 2^ADDR_W
- COUNT_W, 5, width of the samples-per-lag count
- LAG_W, 4, width of the lag count and lag index

Ports:
- ck  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  clock enable; when low all state and outputs hold
- start  in  1  begin a sequence; sampled only when en=1 and idle
- abort  in  1  terminate the current sequence; sampled when en=1
- count  in  COUNT_W  samples per lag; latched at start
- lags  in  LAG_W  number of lags; latched at start
- base_addr  in  ADDR_W  first x address; latched at start
- x_raddr  out  ADDR_W  x read address
- y_raddr  out  ADDR_W  y read address
- ren  out  1  read enable; address pair valid
- first  out  1  high with the first pair of each lag
- last  out  1  high with the final pair of each lag
- lag_idx  out  LAG_W  lag of the current pair
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, RUN. All outputs are registered.
- Reset values: all outputs 0, state IDLE, internal counters 0.
- IDLE to RUN happens on start=1 with en=1. On that transition the block:
  - latches count, lags and base_addr;
  - issues pair k=0 of lag 0.
- In RUN, with en=1, the block issues one pair per cycle:
  - x_raddr = base + k and y_raddr = base + k + lag_idx, both truncated to ADDR_W (wrap, no saturation);
  - k runs 0..count-1, then lag_idx increments and k restarts at 0;
  - there are no idle cycles between lags.
- first=1 when k=0. last=1 when k=count-1. When count=1, first and last are both high.
- After the last pair of lag lags-1 is issued, the next enabled edge:
  - enters IDLE;
  - sets done=1 for one cycle;
  - clears ren, busy, first, last, lag_idx, x_raddr and y_raddr.
- If count=0 or lags=0, start produces no reads. done pulses one enabled cycle after start, and busy stays 0.
- start while busy is ignored. A start in the same cycle that done is high is accepted, because the state is already IDLE.
- abort=1 with en=1:
  - forces IDLE on that edge;
  - clears ren and busy;
  - no done pulse.
  - abort takes priority over start in the same cycle.
- Reset mid-sequence returns to the reset values immediately (asynchronously). No done pulse.
- Input changes to count, lags or base_addr during RUN have no effect.

## Timing
- Latency: start sampled at edge N puts pair 0 on the outputs after edge N.
- A sequence holds ren high for exactly count*lags consecutive enabled cycles. done is high on the enabled cycle after the last ren cycle.
- The downstream RAM has 1-cycle read latency. Consumers delay ren/first/last/lag_idx by one stage to align them with rdata; the MAC's clr comes from first delayed by one stage, and its result capture from last delayed by two stages.
- en=0 stretches the sequence: the outputs hold, and ren stays high if it was high. A held pair counts as one issue.

## Structure
- Shared correlator package holds:
  - the state enum (IDLE, RUN);
  - default widths ADDR_W/COUNT_W/LAG_W, shared with the mac and shifter wrappers.
- One natural sub-module, corr_addr_gen: the k/lag counters plus the modulo address adders. The FSM, latching and handshake stay in corr_seq.

## Test plan
- base=0x00, count=12, lags=1, start one cycle:
  - ren high for 12 cycles;
  - x=y=0..11;
  - first on k=0, last on k=11;
  - done exactly 1 cycle after ren falls.
- base=0xFC, count=8, lags=3:
  - 24 ren cycles, no gaps between lags;
  - lag 2 gives x 0xFC..0x03 (wrap) and y 0xFE..0x05;
  - lag_idx steps 0,1,2.
- count=1, lags=4: first and last high on all 4 ren cycles; done after the 4th.
- count=0 or lags=0: no ren, busy stays 0, done one cycle after start.
- Start while busy is ignored. A new start on the done cycle begins immediately, with pair 0 on the next cycle.
- Abort, en and reset:
  - abort on cycle 5 of a 12x2 run: ren/busy low next cycle, no done;
  - en toggling mid-run: the address sequence is identical to the en=1 run;
  - rst_n pulsed low mid-run: all outputs 0 at once.
